// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush control for the 5-stage core.
// Shadows EX/MEM/WB destinations and compares them with the ID sources.
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter bit FWD_EN  = 1'b1,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wen,
   input  logic              id_load,
   input  logic              id_store,
   input  logic              br_taken,
   input  logic              iready_n,
   input  logic              dready_n,
   input  logic              dbusy,
   output logic              freeze,
   output logic              stall_id,
   output logic              bubble_ex,
   output logic              flush_id,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              wen;
      logic              ld;
      logic              st;
   } slot_t;

   slot_t ex_q, ex_d;
   slot_t mem_q, mem_d;
   slot_t wb_q, wb_d;

   logic             pend_q, pend_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             tflag_q, tflag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       mem_stall;
   logic       do_flush;
   logic       haz;
   logic [2:0] m1;
   logic [2:0] m2;

   // Fields that never influence control; kept only so slots stay uniform.
   logic unused_fields;
   assign unused_fields = ^{wb_q.ld, wb_q.st, ex_q.st};

   function automatic logic hit(
      input slot_t             s,
      input logic [REG_AW-1:0] rs,
      input logic              used,
      input logic              vld
   );
      return vld & used & s.v & s.wen
           & (s.rd != '0) & (s.rd == rs);
   endfunction

   function automatic logic [1:0] sel(
      input logic [2:0] m
   );
      logic [1:0] r;
      r = 2'b00;
      priority case (1'b1)
         m[0]:    r = 2'b01;
         m[1]:    r = 2'b10;
         m[2]:    r = 2'b11;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Source-vs-stage match vectors: bit0 EX, bit1 MEM, bit2 WB.
   always_comb begin
      m1 = '0;
      m2 = '0;
      m1[0] = hit(ex_q,  id_rs1, id_rs1_used, id_valid);
      m1[1] = hit(mem_q, id_rs1, id_rs1_used, id_valid);
      m1[2] = hit(wb_q,  id_rs1, id_rs1_used, id_valid);
      m2[0] = hit(ex_q,  id_rs2, id_rs2_used, id_valid);
      m2[1] = hit(mem_q, id_rs2, id_rs2_used, id_valid);
      m2[2] = hit(wb_q,  id_rs2, id_rs2_used, id_valid);
   end

   // Memory wait, hazard detection and operand select.
   always_comb begin
      mem_stall = iready_n
                | (dready_n & mem_q.ld)
                | (dbusy & mem_q.st);
      haz   = 1'b0;
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_EN) begin
         haz   = (m1[0] | m2[0]) & ex_q.ld;
         fwd_a = sel(m1);
         fwd_b = sel(m2);
      end else begin
         haz = |{m1, m2};
      end
   end

   // Pipeline control: memory wait beats flush beats data hazard.
   always_comb begin
      do_flush  = (br_taken | pend_q) & ~mem_stall;
      freeze    = mem_stall;
      flush_id  = do_flush;
      stall_id  = mem_stall | (haz & ~do_flush);
      bubble_ex = ~mem_stall & (do_flush | haz);
   end

   // Shadow pipeline advances unless frozen.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!mem_stall) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = '0;
         if (!bubble_ex && id_valid) begin
            ex_d.v   = 1'b1;
            ex_d.rd  = id_rd;
            ex_d.wen = id_wen;
            ex_d.ld  = id_load;
            ex_d.st  = id_store;
         end
      end
   end

   // Pending flush, timeout watch and stall statistics.
   always_comb begin
      pend_d = pend_q;
      if (mem_stall && br_taken)
         pend_d = 1'b1;
      else if (do_flush)
         pend_d = 1'b0;

      tmo_d = '0;
      if (mem_stall)
         tmo_d = (tmo_q == TMAX) ? tmo_q : tmo_q + TW'(1);
      tflag_d = tflag_q | (tmo_d == TMAX);

      cnt_d = cnt_q;
      if ((freeze | stall_id) && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         pend_q  <= 1'b0;
         tmo_q   <= '0;
         tflag_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         pend_q  <= pend_d;
         tmo_q   <= tmo_d;
         tflag_q <= tflag_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_timeout  = tflag_q;
   assign stall_cycles = cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall/flush controller for the 5-stage in-order core (IF, ID, EX, MEM, WB). It keeps its own shadow pipeline of destination/memory info for EX, MEM and WB, and compares it against the source registers of the instruction in ID. From that it produces per-stage hold/kill controls and operand-forwarding selects. It also tracks branch flushes that arrive during a memory stall, watches memory stalls for timeout, and counts stall cycles.

## Interface
Parameters:
- REG_AW, 5, register address width
- FWD_EN, 1, 1 = forwarding mode (stall only on load-use); 0 = stall-only mode
- TIMEOUT, 255, consecutive memory-stall cycles before mem_timeout asserts
- CNT_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source registers of ID instruction
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_AW  destination of ID instruction
- id_wen  in  1  ID instruction writes a register
- id_load, id_store  in  1  ID instruction is a load / store
- br_taken  in  1  branch resolved taken in EX
- iready_n, dready_n, dbusy  in  1  memory-system wait signals
- freeze  out  1  hold all pipeline registers
- stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load a nop into ID/EX
- flush_id  out  1  kill the IF/ID instruction
- fwd_a, fwd_b  out  2  operand select for rs1/rs2: 00 regfile, 01 EX, 10 MEM, 11 WB
- mem_timeout  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  saturating count of freeze or stall_id cycles

## Operation
- Shadow slots EX/MEM/WB: {v, rd, wen, ld, st}. On reset all are zero.
- Match rule for a stage S and source n: S.v & S.wen & S.rd != 0 & S.rd == id_rsn & id_rsn_used & id_valid.
- mem_stall = iready_n | (dready_n & MEM.ld) | (dbusy & MEM.st).
- freeze = mem_stall.
- Data hazard, FWD_EN=1: haz = any match at EX with EX.ld = 1 (load-use).
- Data hazard, FWD_EN=0: haz = any match at EX, MEM or WB.
  - The regfile is not write-through, so WB matches stall in this mode.
- Forwarding, FWD_EN=1:
  - fwd_x is set to the nearest matching stage; priority EX > MEM > WB.
  - Otherwise fwd_x = 00.
- Forwarding, FWD_EN=0: fwd_x is always 00.
- Flush:
  - do_flush = (br_taken | flush_pend) & !mem_stall.
  - flush_pend is set when br_taken = 1 during mem_stall. It clears on the cycle do_flush applies.
- Outputs:
  - flush_id = do_flush.
  - stall_id = mem_stall | (haz & !do_flush).
  - bubble_ex = !mem_stall & (do_flush | haz).
- Shadow advance, when freeze = 0:
  - WB <= MEM; MEM <= EX.
  - EX <= (bubble_ex | !id_valid) ? empty : ID info.
- Shadow when freeze = 1: all slots hold.
- Priority: mem_stall > flush > data hazard.
- Timeout counter:
  - Increments on each mem_stall cycle and resets to 0 on any non-stall cycle.
  - When it reaches TIMEOUT, mem_timeout sets and stays set until reset.
  - The counter saturates at TIMEOUT.
- stall_cycles increments when freeze | stall_id, and saturates at all-ones.

## Timing
- freeze, stall_id, bubble_ex, flush_id and fwd_a/fwd_b are combinational from the shadow state, the flags and the current inputs. There is no added latency.
- Shadow slots, flush_pend, the timeout counter, mem_timeout and stall_cycles update on posedge clk.
- Load-use with FWD_EN=1 costs exactly 1 stall cycle. The next cycle forwards from MEM (fwd = 10).
- FWD_EN=0, dependency on the immediately preceding instruction: stall_id is high for 3 cycles (match at EX, then MEM, then WB). The regfile is read on the 4th cycle.
- Reset mid-operation, asynchronously:
  - Shadow slots empty, flush_pend = 0, counters = 0, mem_timeout = 0.
  - Outputs then follow the inputs only: freeze = mem_stall, fwd = 00, others 0 unless mem_stall.
- Simultaneous br_taken and haz, no mem_stall:
  - flush wins, stall_id = 0, bubble_ex = 1.
  - The hazard instruction is discarded.

## Test plan
- FWD_EN=1:
  - Stimulus: lw r5 in EX; ID reads rs1 = r5.
  - Response: stall_id = 1, bubble_ex = 1 for 1 cycle.
  - Next cycle: fwd_a = 10, stall_id = 0. stall_cycles = 1.
- FWD_EN=1, ALU forwarding:
  - Stimulus: add r3 in EX and add r3 in MEM; ID reads rs2 = r3.
  - Response: fwd_b = 01, no stall.
  - r0 destination anywhere gives fwd = 00.
- FWD_EN=0:
  - Stimulus: add r7 followed directly by a reader of r7.
  - Response: stall_id high for exactly 3 cycles, bubble_ex high for 3 cycles.
- Branch flush:
  - br_taken = 1 while dready_n = 1 and MEM holds a load. Response: flush_id = 0, freeze = 1.
  - dready_n drops. Response: flush_id = 1 and bubble_ex = 1 for 1 cycle, flush_pend clears.
- Timeout, TIMEOUT=4:
  - Stimulus: iready_n held high 4 cycles.
  - Response: mem_timeout = 1 after the 4th edge. It stays 1 after iready_n falls and clears only on rst = 0.
- Reset mid-stall:
  - Stimulus: assert rst = 0 during a load-use stall.
  - Response: stall_id = 0, fwd = 00, stall_cycles = 0 immediately, without waiting for a clock edge.
